avalon_bus_arbiter: RTL and testbench

Two-master, one-slave arbiter for the Avalon memory-mapped bus, sitting between `top_level_cpu` (master 0) and a second master (master 1: loader/debug port) in front of the single `RAM` slave. Grants the slave to one master per transfer with round-robin fairness. Masters stall on `waitrequest` until granted and served. A watchdog aborts transfers the slave never completes.

---
 rtl/avalon_bus_arbiter.sv | 145 ++++++++++++++
 tb/tb_avalon_bus_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_bus_arbiter.sv
// Two-master, one-slave Avalon-MM arbiter with round-robin fairness and a
// per-transfer watchdog.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no owner; slave outputs parked at 0, both masters stalled
// ST_OWN0 | master 0 owns the slave for one transfer
// ST_OWN1 | master 1 owns the slave for one transfer
module avalon_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  output logic [1:0]          grant,
  output logic                timeout_err
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // The abort fires in the cycle whose increment would make the count reach TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {ST_IDLE, ST_OWN0, ST_OWN1} state_t;

  state_t            state;
  state_t            state_next;
  logic              last_owner;
  logic              owner_next;
  logic [CNT_W-1:0]  wd_cnt;
  logic              timeout_set;
  logic              req0;
  logic              req1;
  logic              own_req;
  logic              wd_hit;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;
  assign wd_hit = (TIMEOUT != 0) && (wd_cnt == CNT_LAST);

  // Read data is not gated; only the owning master is allowed to sample it.
  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;

  // Next-state, slave mux and per-master stall generation.
  always_comb begin
    state_next     = state;
    owner_next     = last_owner;
    timeout_set    = 1'b0;
    own_req        = 1'b0;
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    grant          = 2'b00;
    unique case (state)
      ST_IDLE: begin
        // On contention, the master that did not own last goes first.
        if (req0 && (!req1 || last_owner)) begin
          state_next = ST_OWN0;
          owner_next = 1'b0;
        end else if (req1) begin
          state_next = ST_OWN1;
          owner_next = 1'b1;
        end
      end
      ST_OWN0: begin
        own_req        = req0;
        s_address      = m0_address;
        s_read         = m0_read & ~m0_write;
        s_write        = m0_write;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        m0_waitrequest = s_waitrequest;
        grant          = 2'b01;
      end
      ST_OWN1: begin
        own_req        = req1;
        s_address      = m1_address;
        s_read         = m1_read & ~m1_write;
        s_write        = m1_write;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        m1_waitrequest = s_waitrequest;
        grant          = 2'b10;
      end
      default: state_next = ST_IDLE;
    endcase
    // Drop and completion take priority over the watchdog.
    if (state != ST_IDLE) begin
      if (!own_req || !s_waitrequest) begin
        state_next = ST_IDLE;
      end else if (wd_hit) begin
        state_next  = ST_IDLE;
        timeout_set = 1'b1;
      end
    end
  end

  // State, fairness pointer, watchdog counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      last_owner  <= 1'b1;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      state      <= state_next;
      last_owner <= owner_next;
      if (state == ST_IDLE) begin
        wd_cnt <= '0;
      end else if (wd_cnt != '1) begin
        wd_cnt <= wd_cnt + CNT_W'(1);
      end
      if (timeout_set) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Bench for avalon_bus_arbiter: directed scenarios plus a randomized run
// against a transaction-level ownership model.
module tb_avalon_bus_arbiter;

  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic [31:0] m0_address, m1_address, s_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata, s_writedata;
  logic [3:0]  m0_byteenable, m1_byteenable, s_byteenable;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata, s_readdata;
  logic        s_read, s_write, s_waitrequest;
  logic [1:0]  grant;
  logic        timeout_err;

  int errors;
  int checks;

  // Reference model: who owns the slave (-1 = nobody), who owned it last,
  // how many cycles the current owner has already held it, sticky error.
  int mdl_own;
  int mdl_last;
  int mdl_held;
  bit mdl_err;

  avalon_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL sim_timeout: bench did not finish within time limit");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0;
    m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '0;
    s_waitrequest = 0; s_readdata = '0;
  endtask

  task automatic model_reset();
    mdl_own = -1; mdl_last = 1; mdl_held = 0; mdl_err = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    next_cycle();
    next_cycle();
    reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", grant); end
    checks++; if (s_read !== 1'b0) begin errors++; $display("FAIL reset_s_read: got %b want 0", s_read); end
    checks++; if (s_write !== 1'b0) begin errors++; $display("FAIL reset_s_write: got %b want 0", s_write); end
    checks++; if (m0_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_m0_wait: got %b want 1", m0_waitrequest); end
    checks++; if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_m1_wait: got %b want 1", m1_waitrequest); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
  endtask

  task automatic test_single_write();
    next_cycle();
    m0_write = 1; m0_address = 32'h4; m0_writedata = 32'h0FF0; m0_byteenable = 4'hF; s_waitrequest = 0;
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL single_req_grant: got %b want 00", grant); end
    checks++; if (m0_waitrequest !== 1'b1) begin errors++; $display("FAIL single_req_wait: got %b want 1", m0_waitrequest); end
    checks++; if (s_write !== 1'b0) begin errors++; $display("FAIL single_req_s_write: got %b want 0", s_write); end
    next_cycle();
    @(negedge clk);
    checks++; if (s_write !== 1'b1) begin errors++; $display("FAIL single_s_write: got %b want 1", s_write); end
    checks++; if (s_read !== 1'b0) begin errors++; $display("FAIL single_s_read: got %b want 0", s_read); end
    checks++; if (s_address !== 32'h4) begin errors++; $display("FAIL single_addr: got %h want 00000004", s_address); end
    checks++; if (s_writedata !== 32'h0FF0) begin errors++; $display("FAIL single_data: got %h want 00000ff0", s_writedata); end
    checks++; if (s_byteenable !== 4'hF) begin errors++; $display("FAIL single_be: got %h want f", s_byteenable); end
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant: got %b want 01", grant); end
    checks++; if (m0_waitrequest !== 1'b0) begin errors++; $display("FAIL single_m0_wait: got %b want 0", m0_waitrequest); end
    checks++; if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL single_m1_wait: got %b want 1", m1_waitrequest); end
    next_cycle();
    m0_write = 0;
    @(negedge clk);
    checks++; if (m0_waitrequest !== 1'b1) begin errors++; $display("FAIL single_after_wait: got %b want 1", m0_waitrequest); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL single_after_grant: got %b want 00", grant); end
    checks++; if (s_write !== 1'b0) begin errors++; $display("FAIL single_after_s_write: got %b want 0", s_write); end
  endtask

  task automatic test_contention();
    do_reset();
    next_cycle();
    m0_read = 1; m0_address = 32'h20; m1_read = 1; m1_address = 32'h30; s_waitrequest = 0;
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL cont_idle_grant: got %b want 00", grant); end
    next_cycle();
    @(negedge clk);
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL cont_first_grant: got %b want 01", grant); end
    checks++; if (s_read !== 1'b1) begin errors++; $display("FAIL cont_first_read: got %b want 1", s_read); end
    checks++; if (s_address !== 32'h20) begin errors++; $display("FAIL cont_first_addr: got %h want 00000020", s_address); end
    checks++; if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL cont_first_m1_wait: got %b want 1", m1_waitrequest); end
    checks++; if (m0_waitrequest !== 1'b0) begin errors++; $display("FAIL cont_first_m0_wait: got %b want 0", m0_waitrequest); end
    next_cycle();
    m0_read = 0;
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL cont_bubble_grant: got %b want 00", grant); end
    checks++; if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL cont_bubble_m1_wait: got %b want 1", m1_waitrequest); end
    next_cycle();
    @(negedge clk);
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL cont_second_grant: got %b want 10", grant); end
    checks++; if (s_address !== 32'h30) begin errors++; $display("FAIL cont_second_addr: got %h want 00000030", s_address); end
    checks++; if (m1_waitrequest !== 1'b0) begin errors++; $display("FAIL cont_second_m1_wait: got %b want 0", m1_waitrequest); end
    next_cycle();
    m1_read = 0;
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL cont_end_grant: got %b want 00", grant); end
  endtask

  task automatic test_alternation();
    logic [1:0] want;
    int prev;
    int cur;
    do_reset();
    next_cycle();
    m0_read = 1; m0_address = 32'hA0; m1_write = 1; m1_address = 32'hB0; s_waitrequest = 0;
    prev = -1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (i % 2 == 0) want = 2'b00;
      else want = (((i - 1) / 2) % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if (grant !== want) begin errors++; $display("FAIL alt_grant[%0d]: got %b want %b", i, grant, want); end
      if (grant != 2'b00) begin
        cur = (grant == 2'b01) ? 0 : 1;
        checks++; if (cur == prev) begin errors++; $display("FAIL alt_repeat[%0d]: master %0d served twice, want other", i, cur); end
        prev = cur;
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_wait_states();
    do_reset();
    next_cycle();
    m1_read = 1; m1_address = 32'h10; s_waitrequest = 1; s_readdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL ws_idle_grant: got %b want 00", grant); end
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      if (k == 1) begin m0_write = 1; m0_address = 32'h40; m0_writedata = 32'h55; m0_byteenable = 4'h3; end
      s_waitrequest = (k < 4);
      s_readdata = (k == 4) ? 32'h0000_0008 : 32'hDEAD_BEEF;
      @(negedge clk);
      checks++; if (grant !== 2'b10) begin errors++; $display("FAIL ws_grant[%0d]: got %b want 10", k, grant); end
      checks++; if (s_address !== 32'h10) begin errors++; $display("FAIL ws_addr[%0d]: got %h want 00000010", k, s_address); end
      checks++; if (m0_waitrequest !== 1'b1) begin errors++; $display("FAIL ws_m0_wait[%0d]: got %b want 1", k, m0_waitrequest); end
      checks++; if (m1_waitrequest !== (k < 4)) begin errors++; $display("FAIL ws_m1_wait[%0d]: got %b want %0d", k, m1_waitrequest, (k < 4)); end
      if (k == 4) begin
        checks++; if (m1_readdata !== 32'h0000_0008) begin errors++; $display("FAIL ws_readdata: got %h want 00000008", m1_readdata); end
      end
    end
    next_cycle();
    m1_read = 0;
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL ws_bubble_grant: got %b want 00", grant); end
    checks++; if (m0_waitrequest !== 1'b1) begin errors++; $display("FAIL ws_bubble_m0_wait: got %b want 1", m0_waitrequest); end
    next_cycle();
    @(negedge clk);
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL ws_m0_grant: got %b want 01", grant); end
    checks++; if (s_write !== 1'b1) begin errors++; $display("FAIL ws_m0_write: got %b want 1", s_write); end
    checks++; if (s_address !== 32'h40) begin errors++; $display("FAIL ws_m0_addr: got %h want 00000040", s_address); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_watchdog();
    do_reset();
    next_cycle();
    m0_read = 1; m0_address = 32'h50; s_waitrequest = 1;
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL wd_idle_grant: got %b want 00", grant); end
    for (int k = 1; k <= TO; k++) begin
      next_cycle();
      @(negedge clk);
      checks++; if (grant !== 2'b01) begin errors++; $display("FAIL wd_own_grant[%0d]: got %b want 01", k, grant); end
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL wd_own_err[%0d]: got %b want 0", k, timeout_err); end
    end
    next_cycle();
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL wd_abort_grant: got %b want 00", grant); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL wd_abort_err: got %b want 1", timeout_err); end
    next_cycle();
    @(negedge clk);
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL wd_regrant: got %b want 01", grant); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL wd_sticky_err: got %b want 1", timeout_err); end
    checks++; if (s_read !== 1'b1) begin errors++; $display("FAIL wd_regrant_read: got %b want 1", s_read); end
    reset = 1;
    next_cycle();
    reset = 0;
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL wd_rst_grant: got %b want 00", grant); end
    checks++; if (s_read !== 1'b0) begin errors++; $display("FAIL wd_rst_read: got %b want 0", s_read); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL wd_rst_err: got %b want 0", timeout_err); end
    checks++; if (m0_waitrequest !== 1'b1) begin errors++; $display("FAIL wd_rst_m0_wait: got %b want 1", m0_waitrequest); end
    clear_inputs();
  endtask

  task automatic randomize_master(inout logic rd, inout logic wr);
    int r;
    if ($urandom_range(0, 3) == 0) begin
      r = $urandom_range(0, 3);
      rd = r[0];
      wr = r[1];
    end
  endtask

  task automatic test_random();
    logic [1:0]  e_grant;
    logic        e_sr, e_sw, e_w0, e_w1;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;
    bit          req0, req1, req_own;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      next_cycle();
      reset = ($urandom_range(0, 63) == 0);
      randomize_master(m0_read, m0_write);
      randomize_master(m1_read, m1_write);
      m0_address = $urandom; m0_writedata = $urandom; m0_byteenable = 4'($urandom);
      m1_address = $urandom; m1_writedata = $urandom; m1_byteenable = 4'($urandom);
      s_waitrequest = 1'($urandom_range(0, 1));
      s_readdata = $urandom;
      @(negedge clk);
      e_grant = 2'b00; e_sr = 0; e_sw = 0; e_addr = '0; e_wd = '0; e_be = '0; e_w0 = 1; e_w1 = 1;
      if (mdl_own == 0) begin
        e_grant = 2'b01; e_sr = m0_read && !m0_write; e_sw = m0_write;
        e_addr = m0_address; e_wd = m0_writedata; e_be = m0_byteenable; e_w0 = s_waitrequest;
      end else if (mdl_own == 1) begin
        e_grant = 2'b10; e_sr = m1_read && !m1_write; e_sw = m1_write;
        e_addr = m1_address; e_wd = m1_writedata; e_be = m1_byteenable; e_w1 = s_waitrequest;
      end
      checks++; if (grant !== e_grant) begin errors++; $display("FAIL rnd_grant[%0d]: got %b want %b", c, grant, e_grant); end
      checks++; if (s_read !== e_sr) begin errors++; $display("FAIL rnd_s_read[%0d]: got %b want %b", c, s_read, e_sr); end
      checks++; if (s_write !== e_sw) begin errors++; $display("FAIL rnd_s_write[%0d]: got %b want %b", c, s_write, e_sw); end
      checks++; if (s_address !== e_addr) begin errors++; $display("FAIL rnd_addr[%0d]: got %h want %h", c, s_address, e_addr); end
      checks++; if (s_writedata !== e_wd) begin errors++; $display("FAIL rnd_wdata[%0d]: got %h want %h", c, s_writedata, e_wd); end
      checks++; if (s_byteenable !== e_be) begin errors++; $display("FAIL rnd_be[%0d]: got %h want %h", c, s_byteenable, e_be); end
      checks++; if (m0_waitrequest !== e_w0) begin errors++; $display("FAIL rnd_m0_wait[%0d]: got %b want %b", c, m0_waitrequest, e_w0); end
      checks++; if (m1_waitrequest !== e_w1) begin errors++; $display("FAIL rnd_m1_wait[%0d]: got %b want %b", c, m1_waitrequest, e_w1); end
      checks++; if (m0_readdata !== s_readdata || m1_readdata !== s_readdata) begin errors++; $display("FAIL rnd_readdata[%0d]: got %h/%h want %h", c, m0_readdata, m1_readdata, s_readdata); end
      checks++; if (timeout_err !== mdl_err) begin errors++; $display("FAIL rnd_timeout_err[%0d]: got %b want %b", c, timeout_err, mdl_err); end
      req0 = m0_read || m0_write;
      req1 = m1_read || m1_write;
      if (reset) begin
        model_reset();
      end else if (mdl_own < 0) begin
        if (req0 && req1) mdl_own = (mdl_last == 1) ? 0 : 1;
        else if (req0) mdl_own = 0;
        else if (req1) mdl_own = 1;
        if (mdl_own >= 0) begin mdl_last = mdl_own; mdl_held = 0; end
      end else begin
        req_own = (mdl_own == 0) ? req0 : req1;
        if (!req_own || !s_waitrequest) mdl_own = -1;
        else if (mdl_held + 1 >= TO) begin mdl_own = -1; mdl_err = 1; end
        else mdl_held++;
      end
    end
    reset = 0;
    clear_inputs();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1;
    clear_inputs();
    model_reset();
    test_reset();
    test_single_write();
    test_contention();
    test_alternation();
    test_wait_states();
    test_watchdog();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
